ddr_rd_burst_ctrl: RTL and testbench

AXI4 read master that fetches a frame region from DDR3 in fixed-length bursts and pushes every returned 256-bit beat into the write side of the DDR read FIFO (256-bit in / 32-bit out asynchronous FIFO). It runs entirely in the DDR user clock domain, the same domain as the FIFO's write port. Bursts are throttled by the FIFO write water level, so a burst is only requested when the whole burst is guaranteed to fit. At most one burst is outstanding at a time.

---
 rtl/ddr_rd_burst_ctrl.sv | 126 ++++++++++++
 tb/tb_ddr_rd_burst_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_ctrl.sv
// AXI4 read master: fetches a frame from DDR in bursts sized to fit the FIFO and streams beats to its write port.
// Optional response/rlast checking is compiled in with DDR_RD_ERR_CHK_EN.
module ddr_rd_burst_ctrl #(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 256,
  parameter int BURST_LEN        = 16,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int BEATS_WIDTH      = 20
) (
  input  logic                        ddr_clk,
  input  logic                        ddr_rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       frame_base,
  input  logic [BEATS_WIDTH-1:0]      frame_beats,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  input  logic                        fifo_wr_full,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level,
  output logic                        err
);

  localparam int LEN_W = 9;
  localparam int LVL_W = FIFO_DEPTH_WIDTH + 2;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [LVL_W-1:0] CAPACITY = LVL_W'(1) << FIFO_DEPTH_WIDTH;

  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [BEATS_WIDTH-1:0] remain;
  logic [LEN_W-1:0]       beat_cnt;
  logic [LEN_W-1:0]       burst_len;
  logic [LEN_W-1:0]       blen;
  logic                   fits;
  logic                   beat;
  logic                   burst_end;

  always_comb begin
    blen = (remain < BEATS_WIDTH'(BURST_LEN)) ? LEN_W'(remain) : LEN_W'(BURST_LEN);
    fits = ({1'b0, fifo_wr_water_level} + LVL_W'(blen)) <= CAPACITY;
    m_rready = (state == DATA) && !fifo_wr_full;
    beat = m_rvalid && m_rready;
    burst_end = beat && (beat_cnt == LEN_W'(1));
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (frame_beats == '0) ? DONE : WAIT;
      WAIT: if (fits) state_nxt = ADDR;
      ADDR: if (m_arready) state_nxt = DATA;
      DATA: if (burst_end) state_nxt = (remain == BEATS_WIDTH'(1)) ? DONE : WAIT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // burst_len keeps the issued length, since remain shrinks while the burst drains
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      cur_addr  <= '0;
      remain    <= '0;
      beat_cnt  <= '0;
      burst_len <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr <= frame_base;
        remain   <= frame_beats;
      end
      if (state == ADDR && m_arready) begin
        beat_cnt  <= blen;
        burst_len <= blen;
      end
      if (beat) begin
        beat_cnt <= beat_cnt - LEN_W'(1);
        remain   <= remain - BEATS_WIDTH'(1);
        if (burst_end) cur_addr <= cur_addr + ADDR_WIDTH'(32'(burst_len) * BYTES);
      end
    end
  end

  always_comb begin
    m_arvalid    = (state == ADDR);
    m_araddr     = m_arvalid ? cur_addr : '0;
    m_arlen      = m_arvalid ? 8'(blen - LEN_W'(1)) : '0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    fifo_wr_en   = beat;
    fifo_wr_data = m_rdata;
  end

`ifdef DDR_RD_ERR_CHK_EN
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      err <= 1'b0;
    end else if (beat && ((m_rresp != 2'b00) || (m_rlast != (beat_cnt == LEN_W'(1))))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{m_rresp, m_rlast};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Directed bench for ddr_rd_burst_ctrl: fake AXI slave, frame-level scoreboard checked every cycle,
// plus literal expectations for the burst address sequences.
module tb_ddr_rd_burst_ctrl;
  localparam int AW = 28, DW = 256, BL = 16, FDW = 10, BW = 20;
  localparam int CAP = 1 << FDW;

  logic            ddr_clk = 1'b0;
  logic            ddr_rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   frame_base = '0;
  logic [BW-1:0]   frame_beats = '0;
  logic            busy, done, m_arvalid, m_rready, fifo_wr_en, err;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_arready = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic [1:0]      m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic            m_rvalid = 1'b0;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_full = 1'b0;
  logic [FDW:0]    fifo_wr_water_level = '0;

  ddr_rd_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                      .FIFO_DEPTH_WIDTH(FDW), .BEATS_WIDTH(BW)) dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .start(start), .frame_base(frame_base),
    .frame_beats(frame_beats), .busy(busy), .done(done), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_wr_water_level(fifo_wr_water_level), .err(err));

  initial forever #5 ddr_clk = ~ddr_clk;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard state
  longint exp_addr[$];
  int     exp_len[$];
  longint log_addr[$];
  int     log_len[$];
  bit     exp_busy = 0, done_due = 0, exp_err = 0, prev_arvalid = 0;
  int     prev_level = 0, frame_total = 0, wr_cnt = 0, burst_left = 0;
  int     wr_total = 0, done_count = 0;
  bit     ar_hs = 0, r_hs = 0;
  int     ar_hs_len = 0;
  bit     inject_err = 0, rvalid_en = 1;

  task automatic plan_frame(input longint base, input int beats);
    longint a = base;
    int rem = beats;
    while (rem > 0) begin
      int l = (rem < BL) ? rem : BL;
      exp_addr.push_back(a);
      exp_len.push_back(l - 1);
      a = (a + longint'(l) * (DW / 8)) % (longint'(1) << AW);
      rem -= l;
    end
  endtask

  always @(negedge ddr_clk) begin
    bit due_n;
    due_n = 0;
    ar_hs = 0;
    r_hs = 0;
    if (!ddr_rst_n) begin
      check("reset_outputs", {m_arvalid, m_rready, fifo_wr_en, busy, done, err, m_arlen, m_araddr}, '0);
      exp_addr.delete(); exp_len.delete();
      exp_busy = 0; exp_err = 0; burst_left = 0; wr_cnt = 0; frame_total = 0;
    end else begin
      check("busy", busy, exp_busy);
      check("done", done, done_due);
      check("err", err, exp_err);
      check("wr_en", fifo_wr_en, m_rvalid && m_rready);
      if (m_rready && fifo_wr_full) check("rready_while_full", m_rready, 0);
      if (m_arvalid) begin
        if (exp_addr.size() == 0) check("ar_unexpected", m_arvalid, 0);
        else begin
          check("araddr", m_araddr, exp_addr[0]);
          check("arlen", m_arlen, exp_len[0]);
        end
        if (!prev_arvalid) check("ar_room", (prev_level + int'(m_arlen) + 1) <= CAP, 1);
      end
      if (done) done_count++;
      if (exp_busy) begin
        if (done) exp_busy = 0;
      end else if (start) begin
        exp_busy = 1;
        plan_frame(longint'(frame_base), int'(frame_beats));
        frame_total = int'(frame_beats);
        wr_cnt = 0;
        if (frame_beats == 0) due_n = 1;
      end
      if (m_arvalid && m_arready && exp_addr.size() > 0) begin
        log_addr.push_back(exp_addr[0]);
        log_len.push_back(exp_len[0]);
        burst_left = exp_len[0] + 1;
        ar_hs = 1;
        ar_hs_len = exp_len[0];
        void'(exp_addr.pop_front());
        void'(exp_len.pop_front());
      end
      if (fifo_wr_en) begin
        r_hs = 1;
        check("wr_data", fifo_wr_data[63:0], m_rdata[63:0]);
        if (fifo_wr_data !== m_rdata) check("wr_data_full", 0, 1);
        if (burst_left == 0) check("beat_outside_burst", fifo_wr_en, 0);
`ifdef DDR_RD_ERR_CHK_EN
        if (m_rresp != 2'b00 || m_rlast != (burst_left == 1)) exp_err = 1;
`endif
        burst_left--;
        wr_cnt++;
        wr_total++;
        if (wr_cnt == frame_total) due_n = 1;
        if (wr_cnt > frame_total) check("beats_over_frame", wr_cnt, frame_total);
      end
    end
    done_due = due_n;
    prev_arvalid = m_arvalid;
    prev_level = int'(fifo_wr_water_level);
  end

  // AXI read slave: returns len+1 beats after each address handshake
  initial begin
    int pend = 0, bidx = 0, gbeat = 0;
    forever begin
      @(posedge ddr_clk);
      #1;
      if (!ddr_rst_n) begin
        pend = 0;
        bidx = 0;
      end else begin
        if (r_hs) begin pend--; bidx++; gbeat++; end
        if (ar_hs) begin pend = ar_hs_len + 1; bidx = 0; end
      end
      m_rvalid = (pend > 0) && rvalid_en;
      m_rlast = (pend == 1);
      m_rresp = (inject_err && bidx == 3) ? 2'd2 : 2'd0;
      m_rdata = {8{32'(gbeat) * 32'h9E3779B9 + 32'h1234}};
    end
  end

  task automatic pulse_start(input logic [AW-1:0] base, input int beats);
    @(posedge ddr_clk); #1;
    frame_base = base;
    frame_beats = BW'(beats);
    start = 1;
    @(posedge ddr_clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge ddr_clk);
      n++;
    end
    if (n >= budget) check("timeout_done", 0, 1);
    @(negedge ddr_clk);
    check("busy_fall", busy, 0);
  endtask

  task automatic check_ar(input string name, input int idx, input longint a, input int l);
    if (idx < 0 || idx >= log_addr.size()) check({name, "_missing"}, idx, log_addr.size());
    else begin
      check({name, "_addr"}, log_addr[idx], a);
      check({name, "_len"}, log_len[idx], l);
    end
  endtask

  initial begin
    int base_log, snap, n;
    m_arready = 1;
    #2;
    check("reset_state", {m_arvalid, m_rready, fifo_wr_en, busy, done, err, m_arlen, m_araddr}, '0);
    repeat (3) @(posedge ddr_clk);
    #1 ddr_rst_n = 1;

    // 40 beats: two full bursts and one of 8
    base_log = log_addr.size(); snap = wr_total;
    pulse_start(28'h0001000, 40);
    wait_done(400);
    check("t1_ar_count", log_addr.size() - base_log, 3);
    check_ar("t1_b0", base_log, 64'h0001000, 15);
    check_ar("t1_b1", base_log + 1, 64'h0001200, 15);
    check_ar("t1_b2", base_log + 2, 64'h0001400, 7);
    check("t1_writes", wr_total - snap, 40);

    // FIFO room gating at the exact boundary
    fifo_wr_water_level = 11'd1009;
    pulse_start(28'h0002000, 16);
    repeat (10) @(negedge ddr_clk);
    check("t2_ar_held", m_arvalid, 0);
    @(posedge ddr_clk); #1;
    fifo_wr_water_level = 11'd1008;
    @(negedge ddr_clk);
    check("t2_ar_same_cycle", m_arvalid, 0);
    @(negedge ddr_clk);
    check("t2_ar_next_cycle", m_arvalid, 1);
    @(posedge ddr_clk); #1;
    fifo_wr_water_level = '0;
    wait_done(200);

    // FIFO full stall mid-burst
    snap = wr_total;
    pulse_start(28'h0003000, 32);
    n = 0;
    while (wr_total - snap < 5 && n < 100) begin @(negedge ddr_clk); n++; end
    if (n >= 100) check("t3_timeout", 0, 1);
    @(posedge ddr_clk); #1;
    fifo_wr_full = 1;
    n = wr_total;
    repeat (5) @(negedge ddr_clk);
    check("t3_stall_writes", wr_total - n, 0);
    check("t3_rready_low", m_rready, 0);
    @(posedge ddr_clk); #1;
    fifo_wr_full = 0;
    wait_done(300);
    check("t3_writes", wr_total - snap, 32);

    // Empty frame, then a wrapping frame with a stray start while busy
    base_log = log_addr.size(); snap = done_count;
    pulse_start(28'h0004000, 0);
    @(negedge ddr_clk);
    check("t4_zero_done", done, 1);
    wait_done(20);
    check("t4_no_ar", log_addr.size() - base_log, 0);
    check("t4_done_once", done_count - snap, 1);
    pulse_start(28'hFFFFC00, 40);
    repeat (4) @(negedge ddr_clk);
    pulse_start(28'h0ABCDE0, 3);
    wait_done(400);
    check("t4_ar_count", log_addr.size() - base_log, 3);
    check_ar("t4_b0", base_log, 64'hFFFFC00, 15);
    check_ar("t4_b1", base_log + 1, 64'hFFFFE00, 15);
    check_ar("t4_b2", base_log + 2, 64'h0000000, 7);

    // Short frame below the burst length
    base_log = log_addr.size();
    pulse_start(28'h0009000, 5);
    wait_done(100);
    check_ar("t5_short", base_log, 64'h0009000, 4);

    // Reset in the middle of a burst, then a clean frame
    snap = wr_total;
    pulse_start(28'h0005000, 32);
    n = 0;
    while (wr_total - snap < 7 && n < 100) begin @(negedge ddr_clk); n++; end
    @(posedge ddr_clk); #1;
    ddr_rst_n = 0;
    #1;
    check("t6_rst_outputs", {m_arvalid, m_rready, fifo_wr_en, busy, done, err, m_arlen, m_araddr}, '0);
    repeat (2) @(posedge ddr_clk);
    #1 ddr_rst_n = 1;
    base_log = log_addr.size(); snap = wr_total;
    pulse_start(28'h0007000, 16);
    wait_done(200);
    check("t6_ar_count", log_addr.size() - base_log, 1);
    check_ar("t6_b0", base_log, 64'h0007000, 15);
    check("t6_writes", wr_total - snap, 16);

    // Error response on one beat
    inject_err = 1;
    snap = wr_total;
    pulse_start(28'h0008000, 16);
    wait_done(200);
    inject_err = 0;
    check("t7_writes", wr_total - snap, 16);
    repeat (3) @(negedge ddr_clk);
`ifdef DDR_RD_ERR_CHK_EN
    check("t7_err_sticky", err, 1);
`else
    check("t7_err_tied", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
